// File: rtl/id_decode_issue_pkg.sv
// Shared opcode, ALU op, branch-condition and flag definitions for the decode/issue stage,
// plus the decoded bundle type and the pure field-decode functions.
package id_decode_issue_pkg;

    localparam logic [3:0] OPC_ADD = 4'h0;
    localparam logic [3:0] OPC_SUB = 4'h1;
    localparam logic [3:0] OPC_AND = 4'h2;
    localparam logic [3:0] OPC_OR  = 4'h3;
    localparam logic [3:0] OPC_LW  = 4'h8;
    localparam logic [3:0] OPC_SW  = 4'h9;
    localparam logic [3:0] OPC_LHB = 4'hA;
    localparam logic [3:0] OPC_LLB = 4'hB;
    localparam logic [3:0] OPC_BR  = 4'hC;
    localparam logic [3:0] OPC_JAL = 4'hD;
    localparam logic [3:0] OPC_JR  = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    typedef enum logic [2:0] {
        COND_NE, COND_EQ, COND_GT, COND_LT, COND_GE, COND_LE, COND_OV, COND_UN
    } br_cond_e;

    typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_HALT} state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [3:0] alu_imm;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [7:0] imm8;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       br_taken;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    function automatic logic cond_holds(input logic [2:0] cond, input logic [2:0] flags);
        logic z, v, n, hit;
        z   = flags[FLAG_Z];
        v   = flags[FLAG_V];
        n   = flags[FLAG_N];
        hit = 1'b1;
        case (br_cond_e'(cond))
            COND_NE: hit = ~z;
            COND_EQ: hit = z;
            COND_GT: hit = ~z & ~n;
            COND_LT: hit = n;
            COND_GE: hit = ~n;
            COND_LE: hit = z | n;
            COND_OV: hit = v;
            COND_UN: hit = 1'b1;
        endcase
        return hit;
    endfunction

    function automatic bundle_t decode(input logic [15:0] instr, input logic [2:0] flags);
        bundle_t    b;
        logic [3:0] opc;
        opc        = instr[15:12];
        b          = '0;
        // Memory, branch and pass-through opcodes all use the adder for address/value
        b.alu_op   = opc[3] ? ALU_ADD : opc[2:0];
        b.alu_imm  = instr[3:0];
        b.rd       = instr[11:8];
        b.rs       = instr[7:4];
        b.rt       = instr[3:0];
        b.imm8     = instr[7:0];
        b.reg_we   = ~opc[3] | (opc == OPC_LW) | (opc == OPC_LHB) | (opc == OPC_LLB) | (opc == OPC_JAL);
        b.mem_re   = (opc == OPC_LW);
        b.mem_we   = (opc == OPC_SW);
        b.br_taken = ((opc == OPC_BR) && cond_holds(instr[11:9], flags)) ||
                     (opc == OPC_JAL) || (opc == OPC_JR);
        return b;
    endfunction

endpackage

// File: rtl/id_skid_buf.sv
// Two-entry in-order buffer for decoded bundles, used by id_decode_issue when ID_SKID_EN is
// defined; ready_o is a flop so the upstream ready never depends combinationally on pop_i.
module id_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         pop_i
);

    logic [W-1:0] ent_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   cnt_q, cnt_d;
    logic         ready_q;
    logic         pop;

    assign pop   = pop_i && (cnt_q != 2'd0);
    assign cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop};

    // NOTE: storage arrays are usually left unreset; these two entries are reset because the
    // head entry drives the output fields directly and those must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            if (push_i) begin
                ent_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != 2'd2);
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = ent_q[rd_ptr_q];

endmodule

// File: rtl/id_decode_issue.sv
// Decode/issue stage: splits instructions into ALU/register/memory controls, interlocks BR on
// pending flag updates and stops on HLT. Define ID_SKID_EN for the 2-entry registered-ready buffer.
module id_decode_issue
    import id_decode_issue_pkg::*;
#(
    parameter int FLAG_LAT = 2,
    parameter int ISIZE    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ISIZE-1:0] instr,
    input  logic [2:0]       flags_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       alu_op,
    output logic [3:0]       alu_imm,
    output logic [3:0]       rd,
    output logic [3:0]       rs,
    output logic [3:0]       rt,
    output logic [7:0]       imm8,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             br_taken,
    output logic             halted
);

    localparam logic [2:0] PEND_LOAD = 3'(FLAG_LAT);

    state_e     state_q, state_d;
    logic [2:0] pend_q, pend_d;
    logic [3:0] opc;
    logic       br_block, room, accept;
    bundle_t    dec, out_b;

    assign opc      = instr[15:12];
    assign br_block = in_valid && (opc == OPC_BR) && (pend_q != 3'd0);
    assign in_ready = rst_n && (state_q != ST_HALT) && !br_block && room;
    assign accept   = in_valid && in_ready;
    assign dec      = decode(instr, flags_i);

    // NOTE: every combinational output gets a default before any branch, so no path can hold
    // a previous value and infer a latch.
    always_comb begin
        pend_d = pend_q;
        if (accept && (opc <= OPC_OR)) begin
            pend_d = PEND_LOAD;
        end else if (pend_q != 3'd0) begin
            pend_d = pend_q - 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (accept && (opc == OPC_HLT)) state_d = ST_HALT;
                else if (br_block)              state_d = ST_STALL;
                else                            state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pend_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

`ifdef ID_SKID_EN
    logic                buf_ready;
    logic [BUNDLE_W-1:0] buf_data;

    assign room  = buf_ready;
    assign out_b = bundle_t'(buf_data);

    id_skid_buf #(.W(BUNDLE_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .data_i  (dec),
        .ready_o (buf_ready),
        .valid_o (out_valid),
        .data_o  (buf_data),
        .pop_i   (out_ready)
    );
`else
    logic    out_valid_q;
    bundle_t out_q;

    // A slot frees up in the same cycle the held bundle is taken
    assign room = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_b     = out_q;
`endif

    assign alu_op   = out_b.alu_op;
    assign alu_imm  = out_b.alu_imm;
    assign rd       = out_b.rd;
    assign rs       = out_b.rs;
    assign rt       = out_b.rt;
    assign imm8     = out_b.imm8;
    assign reg_we   = out_b.reg_we;
    assign mem_re   = out_b.mem_re;
    assign mem_we   = out_b.mem_we;
    assign br_taken = out_b.br_taken;
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_id_decode_issue.sv
// Self-checking bench for id_decode_issue: directed scenarios plus a random stream, compared
// each cycle against a queue-based model of accepted-but-unconsumed instructions.
module tb_id_decode_issue;

    localparam int FLAG_LAT = 2;
`ifdef ID_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        reg_we, mem_re, mem_we, br_taken, halted;
    logic [15:0] instr;
    logic [2:0]  flags_i, alu_op;
    logic [3:0]  alu_imm, rd, rs, rt;
    logic [7:0]  imm8;

    always #5 clk = ~clk;

    id_decode_issue #(.FLAG_LAT(FLAG_LAT), .ISIZE(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flags_i(flags_i), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .alu_imm(alu_imm), .rd(rd), .rs(rs), .rt(rt), .imm8(imm8), .reg_we(reg_we),
        .mem_re(mem_re), .mem_we(mem_we), .br_taken(br_taken), .halted(halted)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [30:0] exp_q[$];
    int          edge_cnt       = 0;
    int          last_flag_edge = -100;
    bit          m_halted       = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:0] obs_bundle();
        return {alu_op, alu_imm, rd, rs, rt, imm8, reg_we, mem_re, mem_we, br_taken};
    endfunction

    function automatic logic [30:0] model_decode(input logic [15:0] ins, input logic [2:0] fl);
        int         opc;
        logic [2:0] op;
        bit         we, re, wr, tk, hold, z, v, n;
        opc  = int'(ins[15:12]);
        z    = fl[0];
        v    = fl[1];
        n    = fl[2];
        op   = 3'd0;
        we   = 0; re = 0; wr = 0; tk = 0; hold = 0;
        if (opc < 8) begin
            op = ins[14:12];
            we = 1;
        end else begin
            case (opc)
                8:      begin re = 1; we = 1; end
                9:      wr = 1;
                10, 11: we = 1;
                12: begin
                    case (ins[11:9])
                        0: hold = !z;
                        1: hold = z;
                        2: hold = !z && !n;
                        3: hold = n;
                        4: hold = !n;
                        5: hold = z || n;
                        6: hold = v;
                        default: hold = 1;
                    endcase
                    tk = hold;
                end
                13:      begin we = 1; tk = 1; end
                14:      tk = 1;
                default: ;
            endcase
        end
        return {op, ins[3:0], ins[11:8], ins[7:4], ins[3:0], ins[7:0], we, re, wr, tk};
    endfunction

    // One clock cycle starting at a negedge: drive, check against the model, advance model.
    task automatic step(input logic v, input logic [15:0] ins, input logic ordy,
                        input logic [2:0] fl, output bit acc);
        bit blocked, room, exp_rdy, pop;
        in_valid  = v;
        instr     = ins;
        out_ready = ordy;
        flags_i   = fl;
        #1;
        blocked = v && (ins[15:12] == 4'hC) && ((edge_cnt - last_flag_edge) < FLAG_LAT);
        room    = (CAP == 1) ? (exp_q.size() == 0 || ordy) : (exp_q.size() < CAP);
        exp_rdy = !m_halted && !blocked && room;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("halted", 32'(halted), 32'(m_halted));
        if (exp_q.size() != 0) check("bundle", 32'(obs_bundle()), 32'(exp_q[0]));
        acc = v && exp_rdy;
        pop = (exp_q.size() != 0) && ordy;
        @(posedge clk);
        edge_cnt++;
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(model_decode(ins, fl));
            if (ins[15:12] <= 4'h3) last_flag_edge = edge_cnt;
            if (ins[15:12] == 4'hF) m_halted = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] ins, input int rdy_pct, input logic [2:0] fl,
                         output int cycles);
        bit acc = 1'b0;
        cycles = 0;
        while (!acc && cycles < 40) begin
            step(1'b1, ins, 1'($urandom_range(99) < rdy_pct), fl, acc);
            cycles++;
        end
        check("issue_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit acc;
        repeat (4) step(1'b0, 16'h0000, 1'b1, 3'b000, acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, n_acc, k;
        bit          acc, pend_v;
        logic [15:0] pend_ins;

        rst_n = 1'b0; in_valid = 1'b0; instr = 16'h0; out_ready = 1'b0; flags_i = 3'b000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fields", 32'(obs_bundle()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD then AND back to back
        issue(16'h0123, 100, 3'b000, cyc);
        issue(16'h2456, 100, 3'b000, cyc);
        check("and_back_to_back", 32'(cyc), 32'd1);
        check("and_alu_op", 32'(alu_op), 32'b010);
        drain();

        // SUB then BR EQ, taken and not taken
        issue(16'h1123, 100, 3'b000, cyc);
        issue(16'hC204, 100, 3'b001, cyc);
        check("br_wait_cycles", 32'(cyc), 32'(FLAG_LAT + 1));
        check("br_eq_taken", 32'(br_taken), 32'd1);
        drain();
        issue(16'h1123, 100, 3'b000, cyc);
        issue(16'hC204, 100, 3'b000, cyc);
        check("br_wait_cycles_2", 32'(cyc), 32'(FLAG_LAT + 1));
        check("br_eq_not_taken", 32'(br_taken), 32'd0);
        drain();

        // LW / SW
        issue(16'h8312, 100, 3'b000, cyc);
        check("lw_mem_re", 32'(mem_re), 32'd1);
        check("lw_alu_imm", 32'(alu_imm), 32'h2);
        drain();
        issue(16'h9312, 100, 3'b000, cyc);
        check("sw_mem_we", 32'(mem_we), 32'd1);
        check("sw_alu_op", 32'(alu_op), 32'd0);
        drain();

        // Backpressure: out_ready low for 5 cycles with a continuous stream offered
        n_acc = 0;
        k     = 0;
        repeat (5) begin
            step(1'b1, 16'hB010 + 16'(k), 1'b0, 3'b000, acc);
            if (acc) begin
                n_acc++;
                k++;
            end
        end
        check("stall_accepts", 32'(n_acc), 32'(CAP));
        issue(16'hB010 + 16'(k), 100, 3'b000, cyc);
        drain();

        // Random stream, instr held until accepted
        pend_v   = 1'b0;
        pend_ins = 16'h0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_v && $urandom_range(3) != 0) begin
                pend_v   = 1'b1;
                pend_ins = 16'($urandom);
                if ($urandom_range(3) == 0) pend_ins[15:12] = 4'hC;
                if (pend_ins[15:12] == 4'hF) pend_ins[15:12] = 4'h0;
            end
            step(pend_v, pend_v ? pend_ins : 16'h0, 1'($urandom_range(3) != 0),
                 3'($urandom), acc);
            if (acc) pend_v = 1'b0;
        end
        drain();

        // Reset mid-stream with a bundle held and a flag update pending
        issue(16'h3123, 0, 3'b000, cyc);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_fields", 32'(obs_bundle()), 32'd0);
        exp_q.delete();
        last_flag_edge = -100;
        m_halted       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'hC000, 100, 3'b001, cyc);
        check("br_after_reset", 32'(cyc), 32'd1);
        drain();

        // HLT then ADD: ADD must never issue
        issue(16'hF000, 100, 3'b000, cyc);
        n_acc = 0;
        repeat (8) begin
            step(1'b1, 16'h0123, 1'b1, 3'b000, acc);
            if (acc) n_acc++;
        end
        check("halt_blocks_add", 32'(n_acc), 32'd0);
        check("halted_sticky", 32'(halted), 32'd1);
        check("halt_in_ready", 32'(in_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
